// File: rtl/fifo_block_reader.sv
// Pops words from a FIFO into a wide block (first word in the MSBs) and holds it until accepted.
// Defining FIFO_BLOCK_READER_FLUSH_EN adds a flush input that emits a partially filled block.
module fifo_block_reader #(
    parameter int unsigned DATA_SIZE   = 8,
    parameter int unsigned BLOCK_WORDS = 16,
    localparam int unsigned CW = $clog2(BLOCK_WORDS) + 1,
    localparam int unsigned IW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             fifo_empty,
    input  logic [DATA_SIZE-1:0]             fifo_data,
    output logic                             fifo_read,
    output logic [DATA_SIZE*BLOCK_WORDS-1:0] block_out,
    output logic                             block_valid,
    input  logic                             block_ready,
`ifdef FIFO_BLOCK_READER_FLUSH_EN
    input  logic                             flush,
`endif
    output logic [CW-1:0]                    word_count
);

    typedef enum logic {StFill, StHold} state_t;

    state_t                                  state_q;
    logic [CW-1:0]                           cnt_q;
    logic [CW-1:0]                           cnt_inc;
    logic [BLOCK_WORDS-1:0][DATA_SIZE-1:0]   slots_q;
    logic [IW-1:0]                           wr_idx;
    logic                                    pop;
    logic                                    full_pop;
    logic                                    flush_req;
    logic                                    flush_hit;

`ifdef FIFO_BLOCK_READER_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    // Gated by reset so no word is consumed while the block is being cleared.
    assign pop       = (state_q == StFill) && !fifo_empty && !reset;
    assign fifo_read = pop;
    assign cnt_inc   = cnt_q + CW'(pop);

    // Slot k lives in packed element BLOCK_WORDS-1-k, so the first word lands in the MSBs.
    assign wr_idx    = IW'(BLOCK_WORDS - 1) - cnt_q[IW-1:0];
    assign full_pop  = pop && (cnt_inc == CW'(BLOCK_WORDS));
    assign flush_hit = (state_q == StFill) && flush_req && (cnt_inc != '0);
    assign block_out = slots_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StFill;
            cnt_q       <= '0;
            slots_q     <= '0;
            block_valid <= 1'b0;
            word_count  <= '0;
        end else begin
            case (state_q)
                StFill: begin
                    if (pop) begin
                        slots_q[wr_idx] <= fifo_data;
                        cnt_q           <= cnt_inc;
                    end
                    if (full_pop || flush_hit) begin
                        state_q     <= StHold;
                        block_valid <= 1'b1;
                        word_count  <= cnt_inc;
                    end
                end
                StHold: begin
                    if (block_ready) begin
                        state_q     <= StFill;
                        cnt_q       <= '0;
                        slots_q     <= '0;
                        block_valid <= 1'b0;
                        word_count  <= '0;
                    end
                end
                default: state_q <= StFill;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_block_reader.sv
// Self-checking bench for fifo_block_reader: FIFO model, word-stream reference model and
// a scoreboard monitor that compares every accepted block.
module tb_fifo_block_reader;
    localparam int unsigned DW = 8;
    localparam int unsigned BW = 16;
    localparam int unsigned W  = DW * BW;
    localparam int unsigned CW = $clog2(BW) + 1;

    localparam logic [W-1:0] EXP_RAMP  = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [W-1:0] EXP_FLUSH = {24'hAABBCC, 104'h0};

    logic          clk = 1'b0;
    logic          reset;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_read;
    logic [W-1:0]  block_out;
    logic          block_valid;
    logic          block_ready;
    logic [CW-1:0] word_count;
`ifdef FIFO_BLOCK_READER_FLUSH_EN
    logic          flush = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] data;
        int           cnt;
    } blk_t;

    blk_t          sb[$];
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] stream[$];
    int            errors = 0;
    int            checks = 0;
    logic          pop_seen;
    blk_t          mon_e;
    logic          prev_hold = 1'b0;
    logic [W-1:0]  prev_out;
    int            prev_cnt;

    always #5 clk = ~clk;

    fifo_block_reader #(
        .DATA_SIZE  (DW),
        .BLOCK_WORDS(BW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_read  (fifo_read),
        .block_out  (block_out),
        .block_valid(block_valid),
        .block_ready(block_ready),
`ifdef FIFO_BLOCK_READER_FLUSH_EN
        .flush      (flush),
`endif
        .word_count (word_count)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? '0 : fifo_q[0];
    endtask

    // Reference: blocks are the pushed word stream cut into BW-word chunks, first word on top.
    task automatic emit(input int n);
        blk_t e;
        e.data = '0;
        foreach (stream[i]) e.data = (e.data << DW) | W'(stream[i]);
        e.data = e.data << (DW * (BW - n));
        e.cnt  = n;
        sb.push_back(e);
        stream.delete();
    endtask

    task automatic push_word(input logic [DW-1:0] b);
        fifo_q.push_back(b);
        stream.push_back(b);
        refresh();
        if (stream.size() == BW) emit(BW);
    endtask

    task automatic wait_valid(input int maxc);
        int i;
        i = 0;
        while (block_valid !== 1'b1 && i < maxc) begin
            @(negedge clk);
            i++;
        end
        chk_int("wait_valid", int'(block_valid), 1);
    endtask

    // FIFO model: pop decided from fifo_read at the edge, applied just after it.
    always @(posedge clk) begin
        pop_seen = fifo_read;
        #1;
        if (pop_seen === 1'b1) begin
            checks++;
            if (fifo_q.size() == 0) begin
                errors++;
                $display("FAIL underflow: fifo_read=1 expected 0 on empty fifo");
            end else begin
                void'(fifo_q.pop_front());
            end
            refresh();
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (reset !== 1'b0) begin
            prev_hold = 1'b0;
        end else if (block_valid === 1'b1) begin
            chk_int("hold_no_read", int'(fifo_read), 0);
            if (prev_hold) begin
                chk("hold_stable_out", block_out, prev_out);
                chk_int("hold_stable_cnt", int'(word_count), prev_cnt);
            end
            if (block_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_block: got %h expected none", block_out);
                end else begin
                    mon_e = sb.pop_front();
                    chk("block_out", block_out, mon_e.data);
                    chk_int("word_count", int'(word_count), mon_e.cnt);
                end
                prev_hold = 1'b0;
            end else begin
                prev_hold = 1'b1;
                prev_out  = block_out;
                prev_cnt  = int'(word_count);
            end
        end else begin
            if (prev_hold) chk_int("valid_dropped", int'(block_valid), 1);
            prev_hold = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0]  exp_hold;
        logic [DW-1:0] first_w;
        int            n;
        int            pushed;

        reset       = 1'b1;
        block_ready = 1'b0;
        refresh();
        for (int i = 0; i < 16; i++) push_word(DW'(i));
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_int("rst_valid", int'(block_valid), 0);
        chk_int("rst_count", int'(word_count), 0);
        chk("rst_block", block_out, '0);
        chk_int("rst_no_read", int'(fifo_read), 0);

        // Ramp block, ready held high.
        block_ready = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (fifo_read === 1'b1) n++;
        end
        chk_int("pop_burst", n, 16);
        @(negedge clk);
        chk_int("ramp_valid", int'(block_valid), 1);
        chk("ramp_block", block_out, EXP_RAMP);
        chk_int("ramp_count", int'(word_count), 16);
        @(negedge clk);
        chk_int("ramp_one_cycle", int'(block_valid), 0);

        // Back-pressure.
        @(posedge clk);
        #1 block_ready = 1'b0;
        for (int i = 0; i < 16; i++) push_word(DW'($urandom));
        exp_hold = sb[0].data;
        wait_valid(40);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_int("bp_no_read", int'(fifo_read), 0);
            chk("bp_block", block_out, exp_hold);
        end
        @(posedge clk);
        #1 block_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_int("bp_accept", int'(block_valid), 0);

        // FIFO runs dry after 7 words.
        @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) push_word(DW'(8'h30 + i));
        repeat (10) @(negedge clk);
        chk_int("stall_valid", int'(block_valid), 0);
        chk_int("stall_no_read", int'(fifo_read), 0);
        @(posedge clk);
        #1;
        for (int i = 7; i < 16; i++) push_word(DW'(8'h30 + i));
        wait_valid(30);
        @(negedge clk);

        // Reset after 5 pops discards them.
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) push_word(DW'(8'h50 + i));
        repeat (8) @(posedge clk);
        #3 reset = 1'b1;
        stream.delete();
        #1;
        chk_int("mid_rst_valid", int'(block_valid), 0);
        chk_int("mid_rst_read", int'(fifo_read), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        first_w = DW'($urandom);
        push_word(first_w);
        for (int i = 1; i < 16; i++) push_word(DW'($urandom));
        wait_valid(40);
        chk("mid_rst_msb", W'(block_out[W-1 -: DW]), W'(first_w));
        @(negedge clk);

        // Reset while holding drops valid without a clock.
        @(posedge clk);
        #1 block_ready = 1'b0;
        for (int i = 0; i < 16; i++) push_word(DW'($urandom));
        wait_valid(40);
        @(posedge clk);
        #3 reset = 1'b1;
        sb.delete();
        stream.delete();
        #1;
        chk_int("hold_rst_valid", int'(block_valid), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        block_ready = 1'b1;

`ifdef FIFO_BLOCK_READER_FLUSH_EN
        push_word(8'hAA);
        push_word(8'hBB);
        push_word(8'hCC);
        repeat (5) @(posedge clk);
        #1 flush = 1'b1;
        emit(3);
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_block", block_out, EXP_FLUSH);
        chk_int("flush_count", int'(word_count), 3);
        @(negedge clk);
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk_int("flush0_valid", int'(block_valid), 0);
        chk_int("flush0_count", int'(word_count), 0);
        block_ready = 1'b0;
        for (int i = 0; i < 16; i++) push_word(DW'($urandom));
        wait_valid(40);
        @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk_int("flush_hold_valid", int'(block_valid), 1);
        chk_int("flush_hold_count", int'(word_count), 16);
        @(posedge clk);
        #1 block_ready = 1'b1;
`endif

        // Random traffic: 6 blocks with random arrivals and back-pressure.
        pushed = 0;
        for (int c = 0; c < 1000 && pushed < 96; c++) begin
            @(posedge clk);
            #1 block_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0) begin
                push_word(DW'($urandom));
                pushed++;
            end
        end
        chk_int("rand_pushed", pushed, 96);
        @(posedge clk);
        #1 block_ready = 1'b1;
        for (int c = 0; c < 300 && sb.size() != 0; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk_int("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_block_reader.md
FIFO_BLOCK_READER -- requirements
Module: fifo_block_reader

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous, active-high reset named reset.
REQ-002 Parameter DATA_SIZE SHALL default to 8 and set the width of one FIFO word in bits.
REQ-003 Parameter BLOCK_WORDS SHALL default to 16 and set the number of words per assembled block.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 fifo_empty  input  1  FIFO empty flag; 1 means there is no word to read.
REQ-007 fifo_data  input  DATA_SIZE  FIFO head word, valid whenever fifo_empty=0.
REQ-008 fifo_read  output  1  pop strobe; the FIFO advances at the next clk edge.
REQ-009 block_out  output  DATA_SIZE*BLOCK_WORDS  assembled block.
REQ-010 block_valid  output  1  block_out and word_count are valid.
REQ-011 block_ready  input  1  downstream accepts the block.
REQ-012 word_count  output  $clog2(BLOCK_WORDS)+1  number of valid words in block_out.
REQ-013 flush  input  1  emit a partial block; this port exists only when FIFO_BLOCK_READER_FLUSH_EN is defined.

Function
REQ-014 The FSM SHALL have exactly two states: FILL and HOLD.
REQ-015 In FILL, fifo_read SHALL be combinationally equal to ~fifo_empty; in HOLD, fifo_read SHALL be 0.
REQ-016 On every clk edge with fifo_read=1, fifo_data SHALL be captured into word slot cnt, and cnt SHALL increment.
REQ-017 Slot k SHALL occupy block_out bits [DATA_SIZE*(BLOCK_WORDS-k)-1 : DATA_SIZE*(BLOCK_WORDS-k-1)], so the first word popped is the most significant.
REQ-018 When the pop that fills slot BLOCK_WORDS-1 occurs, the FSM SHALL move to HOLD, and block_valid SHALL be 1 on the following cycle.
REQ-019 In HOLD, block_valid SHALL be 1 and word_count SHALL be held; in FILL, block_valid SHALL be 0.
REQ-020 In HOLD, block_out and word_count SHALL remain stable until the edge where block_valid=1 and block_ready=1.
REQ-021 On that accept edge, the FSM SHALL return to FILL, cnt SHALL clear to 0, and block_out SHALL clear to 0.
REQ-022 No pop SHALL occur in the accept cycle; the first pop of the next block SHALL be possible one cycle later.
REQ-023 Back-to-back pops SHALL be supported, so a full block SHALL take BLOCK_WORDS cycles when fifo_empty stays 0.
REQ-024 block_ready asserted while in FILL SHALL be ignored.
REQ-025 When fifo_empty=1 in FILL, the block SHALL stall with all state held and no timeout.
REQ-026 block_out slots not yet written SHALL read as 0.

Reset
REQ-027 Reset SHALL force state FILL, cnt=0, block_out=0, block_valid=0, and word_count=0, with fifo_read=0 while reset is asserted.
REQ-028 Reset asserted mid-block SHALL discard the partial block; words already popped SHALL be lost and SHALL NOT be re-read.
REQ-029 Reset asserted in HOLD SHALL drop block_valid immediately, without waiting for clk.

Configuration
REQ-030 With macro FIFO_BLOCK_READER_FLUSH_EN defined, the flush port SHALL exist, and flush=1 in FILL with a post-edge count in 1..BLOCK_WORDS-1 SHALL move the FSM to HOLD with word_count equal to that count and unused slots at 0.
REQ-031 With FIFO_BLOCK_READER_FLUSH_EN defined, a pop and flush in the same cycle SHALL capture the word first, then apply the flush to the incremented count.
REQ-032 With FIFO_BLOCK_READER_FLUSH_EN defined, flush with count 0, or flush in HOLD, SHALL be ignored.
REQ-033 Without FIFO_BLOCK_READER_FLUSH_EN, the flush port SHALL be absent, and word_count SHALL equal BLOCK_WORDS whenever block_valid=1.

Verification
REQ-034 Default parameters, 16 words 0x00..0x0F preloaded, block_ready=1: the bench SHALL check 16 consecutive fifo_read pulses, then block_valid=1 for one cycle with block_out=0x000102...0F and word_count=16.
REQ-035 block_ready=0 for 5 cycles after block_valid rises: the bench SHALL check block_out stays stable, fifo_read=0, and acceptance on the first ready cycle.
REQ-036 FIFO runs empty after 7 words, then 9 more words arrive 10 cycles later: the bench SHALL check a single block containing all 16 words in order.
REQ-037 Reset pulsed after 5 pops: the bench SHALL check block_valid=0, and that the next block starts at slot 0 with the 6th FIFO word in the MSB position.
REQ-038 With FIFO_BLOCK_READER_FLUSH_EN defined, flush asserted after 3 words 0xAA,0xBB,0xCC: the bench SHALL check block_out=0xAABBCC followed by 13 zero bytes and word_count=3.
REQ-039 With FIFO_BLOCK_READER_FLUSH_EN defined, flush asserted with count 0, and flush asserted during HOLD: the bench SHALL check no state change in either case.
